// File: rtl/barrel_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
package barrel_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  function automatic logic is_rot(
    input logic [OP_W-1:0] op
  );
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Index of the last log stage feeding pipeline register g.
  function automatic int grp_last(
    input int g,
    input int spr,
    input int amt_w
  );
    int e;
    e = (g + 1) * spr;
    if (e > amt_w) e = amt_w;
    return e - 1;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational log stage: shifts/rotates by SHIFT when enabled.
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] d_o,
  output logic             c_o
);

  always_comb begin
    d_o = d_i;
    c_o = c_i;
    if (en_i) begin
      case (op_i)
        OP_SLL: begin
          d_o = {d_i[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
          c_o = d_i[WIDTH-SHIFT];
        end
        OP_SRL: begin
          d_o = {{SHIFT{1'b0}}, d_i[WIDTH-1:SHIFT]};
          c_o = d_i[SHIFT-1];
        end
        OP_SRA: begin
          d_o = {{SHIFT{d_i[WIDTH-1]}}, d_i[WIDTH-1:SHIFT]};
          c_o = d_i[SHIFT-1];
        end
        // Rotate carry is taken from the final result instead.
        OP_ROL: begin
          d_o = {d_i[WIDTH-1-SHIFT:0], d_i[WIDTH-1:WIDTH-SHIFT]};
        end
        OP_ROR: begin
          d_o = {d_i[SHIFT-1:0], d_i[WIDTH-1:SHIFT]};
        end
        default: begin
          d_o = d_i;
          c_o = c_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shift.sv
// Pipelined barrel shifter: log stages grouped between registers,
// single global stall driven by the output handshake.
module pipelined_barrel_shift
  import barrel_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int STAGES_PER_REG = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic                     out_carry,
  output logic                     out_zero
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int SPR   = STAGES_PER_REG;
  localparam int LAT   = (AMT_W + SPR - 1) / SPR;

  logic [WIDTH-1:0] src_d   [LAT];
  logic             src_c   [LAT];
  logic [OP_W-1:0]  src_op  [LAT];
  logic [AMT_W-1:0] src_amt [LAT];
  logic             src_v   [LAT];

  logic [WIDTH-1:0] st_d [AMT_W];
  logic             st_c [AMT_W];

  logic [WIDTH-1:0] data_q  [LAT];
  logic [WIDTH-1:0] data_d  [LAT];
  logic             carry_q [LAT];
  logic             carry_d [LAT];
  logic [OP_W-1:0]  op_q    [LAT];
  logic [OP_W-1:0]  op_d    [LAT];
  logic [AMT_W-1:0] amt_q   [LAT];
  logic [AMT_W-1:0] amt_d   [LAT];
  logic             valid_q [LAT];
  logic             valid_d [LAT];

  logic advance;

  assign advance  = out_ready | ~valid_q[LAT-1];
  assign in_ready = advance;

  always_comb begin
    src_d[0]   = in_a;
    src_c[0]   = 1'b0;
    src_op[0]  = in_op;
    src_amt[0] = in_amt;
    src_v[0]   = in_valid;
    for (int g = 1; g < LAT; g++) begin
      src_d[g]   = data_q[g-1];
      src_c[g]   = carry_q[g-1];
      src_op[g]  = op_q[g-1];
      src_amt[g] = amt_q[g-1];
      src_v[g]   = valid_q[g-1];
    end
  end

  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    localparam int G = i / SPR;
    logic [WIDTH-1:0] din;
    logic             cin;

    if (i % SPR == 0) begin : g_head
      assign din = src_d[G];
      assign cin = src_c[G];
    end else begin : g_body
      assign din = st_d[i-1];
      assign cin = st_c[i-1];
    end

    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << i)
    ) u_stage (
      .d_i  (din),
      .en_i (src_amt[G][i]),
      .op_i (src_op[G]),
      .c_i  (cin),
      .d_o  (st_d[i]),
      .c_o  (st_c[i])
    );
  end

  always_comb begin
    for (int g = 0; g < LAT; g++) begin
      data_d[g]  = st_d[grp_last(g, SPR, AMT_W)];
      carry_d[g] = st_c[grp_last(g, SPR, AMT_W)];
      op_d[g]    = src_op[g];
      amt_d[g]   = src_amt[g];
      valid_d[g] = src_v[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < LAT; g++) begin
        data_q[g]  <= '0;
        carry_q[g] <= 1'b0;
        op_q[g]    <= '0;
        amt_q[g]   <= '0;
        valid_q[g] <= 1'b0;
      end
    end else if (advance) begin
      for (int g = 0; g < LAT; g++) begin
        data_q[g]  <= data_d[g];
        carry_q[g] <= carry_d[g];
        op_q[g]    <= op_d[g];
        amt_q[g]   <= amt_d[g];
        valid_q[g] <= valid_d[g];
      end
    end
  end

  logic rot_c;

  always_comb begin
    rot_c = (op_q[LAT-1] == OP_ROL) ? out_y[0]
                                    : out_y[WIDTH-1];
    out_carry = carry_q[LAT-1];
    if (is_rot(op_q[LAT-1])) begin
      out_carry = (|amt_q[LAT-1]) & rot_c;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_y     = data_q[LAT-1];
  assign out_zero  = valid_q[LAT-1] & ~|data_q[LAT-1];

endmodule

// File: tb/tb_pipelined_barrel_shift.sv
// Scoreboard bench for pipelined_barrel_shift (WIDTH=32, 2 stages/reg).
module tb_pipelined_barrel_shift;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int LAT = 3;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    int           acc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  y;
    logic          c;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [AW-1:0] in_amt = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_y;
  logic          out_carry;
  logic          out_zero;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_pop = 0;

  vec_t dv[13];
  vec_t bp[6];
  vec_t rv[3];
  vec_t pv;

  pipelined_barrel_shift #(
    .WIDTH          (W),
    .STAGES_PER_REG (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    int n;
    n = 0;
    in_a     = v.a;
    in_op    = v.op;
    in_amt   = v.amt;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) bound_fail("in_ready_wait");
    e.y   = v.y;
    e.c   = v.c;
    e.z   = (v.y == '0);
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) bound_fail("drain");
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !out_ready) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (sb.size() != 0) begin
        chk("stall_hold_y", out_y, sb[0].y);
        chk("stall_hold_c", 32'(out_carry), 32'(sb[0].c));
      end
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        bound_fail("unexpected_beat");
      end else begin
        e = sb.pop_front();
        chk("y", out_y, e.y);
        chk("carry", 32'(out_carry), 32'(e.c));
        chk("zero", 32'(out_zero), 32'(e.z));
        if (e.lat) chk("latency", 32'(cyc - e.acc + 1), 32'(LAT));
        last_pop = cyc;
      end
    end
  end

  initial begin
    int bp_start;
    int seen;

    dv[0]  = '{32'h00000099, 3'd0, 5'd1,  32'h00000132, 1'b0};
    dv[1]  = '{32'h00000099, 3'd1, 5'd4,  32'h00000009, 1'b1};
    dv[2]  = '{32'h80000099, 3'd2, 5'd4,  32'hF8000009, 1'b1};
    dv[3]  = '{32'h00000099, 3'd4, 5'd4,  32'h90000009, 1'b1};
    dv[4]  = '{32'h80000001, 3'd3, 5'd1,  32'h00000003, 1'b1};
    dv[5]  = '{32'h00000099, 3'd0, 5'd31, 32'h80000000, 1'b0};
    dv[6]  = '{32'h00000002, 3'd1, 5'd2,  32'h00000000, 1'b1};
    dv[7]  = '{32'h80000099, 3'd2, 5'd0,  32'h80000099, 1'b0};
    dv[8]  = '{32'h80000001, 3'd4, 5'd0,  32'h80000001, 1'b0};
    dv[9]  = '{32'hDEADBEEF, 3'd7, 5'd13, 32'hDEADBEEF, 1'b0};
    dv[10] = '{32'h12345678, 3'd5, 5'd4,  32'h12345678, 1'b0};
    dv[11] = '{32'h80000000, 3'd2, 5'd31, 32'hFFFFFFFF, 1'b0};
    dv[12] = '{32'h0000F00F, 3'd3, 5'd16, 32'hF00F0000, 1'b0};

    bp[0] = '{32'h00000001, 3'd0, 5'd1, 32'h00000002, 1'b0};
    bp[1] = '{32'h00000080, 3'd1, 5'd3, 32'h00000010, 1'b0};
    bp[2] = '{32'h80000000, 3'd2, 5'd1, 32'hC0000000, 1'b0};
    bp[3] = '{32'h00000001, 3'd4, 5'd1, 32'h80000000, 1'b1};
    bp[4] = '{32'hF0000000, 3'd3, 5'd4, 32'h0000000F, 1'b1};
    bp[5] = '{32'h00000055, 3'd1, 5'd1, 32'h0000002A, 1'b1};

    rv[0] = '{32'h00000011, 3'd0, 5'd2, 32'h00000044, 1'b0};
    rv[1] = '{32'h00000100, 3'd1, 5'd8, 32'h00000001, 1'b0};
    rv[2] = '{32'h0000000F, 3'd3, 5'd4, 32'h000000F0, 1'b0};
    pv    = '{32'h0000000F, 3'd0, 5'd28, 32'hF0000000, 1'b0};

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y", out_y, 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (dv[i]) send(dv[i], 1'b1);
    drain();

    bp_start = cyc + 1;
    fork
      begin
        foreach (bp[i]) send(bp[i], 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_span", 32'(last_pop - bp_start), 32'd10);

    foreach (rv[i]) send(rv[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", out_y, 32'd0);
    chk("midrst_zero", 32'(out_zero), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale", 32'(seen), 32'd0);
    send(pv, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shift.md
Name: pipelined_barrel_shift

Overview:
Parametrised, pipelined successor to the 32-bit combinational barrel shifter used by the ALU. Supports five shift/rotate modes at any power-of-two width, with a configurable number of pipeline registers. Adds carry-out and zero flags and a valid/ready handshake with backpressure. Sits between the ALU operand mux and the ALU result/flag writeback.

Parameters:
WIDTH, 32, data width in bits; power of two, >= 4
STAGES_PER_REG, 2, log-shift stages between pipeline registers; 1..AMT_W
AMT_W, $clog2(WIDTH), derived (localparam), shift-amount width
LAT, ceil(AMT_W/STAGES_PER_REG), derived (localparam), pipeline latency in cycles (default 3)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat present
in_ready  out  1  block accepts input this cycle
in_a  in  WIDTH  operand
in_amt  in  AMT_W  shift amount, 0..WIDTH-1
in_op  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
out_y  out  WIDTH  shifted result
out_carry  out  1  last bit shifted/rotated out
out_zero  out  1  out_y == 0

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valid bits and out_valid = 0; out_y, out_carry, out_zero = 0. Data registers also cleared (no X on outputs).
- Reset mid-operation: every in-flight beat is discarded; no beat is emitted after release until a new input is accepted.
- Global stall: advance = out_ready | ~out_valid; in_ready = advance (combinational). The whole pipeline moves one stage when advance=1 and holds all registers otherwise.
- Input accepted when in_valid & in_ready. A bubble (valid=0) enters when in_valid=0 and advance=1.
- Latency: an accepted beat appears on out_* exactly LAT advancing cycles later. Throughput is 1 beat/cycle with out_ready held high.
- out_* are stable while out_valid=1 & out_ready=0.
- Shift stage i (i = 0..AMT_W-1) shifts by 2^i when amt[i]=1. Stages are grouped STAGES_PER_REG per register; a partial last group is allowed.
- Right modes: SRL fills with 0. SRA fills with a[WIDTH-1]. ROL/ROR wrap bits around.
- Pass-through ops: out_y = in_a, out_carry = 0.
- Carry, with k = amt > 0:
  - SLL: a[WIDTH-k]
  - SRL/SRA: a[k-1]
  - ROL: y[0]
  - ROR: y[WIDTH-1]
- amt = 0 in any mode: y = a, carry = 0.
- out_zero is computed from the final y. It may be registered with y or computed combinationally from it; both must match at out_valid.
- op and amt travel with the data through every pipeline register, so results are never mixed between beats.

Decomposition:
- Shared package barrel_pkg:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR
  - op width constant OP_W = 3
- One sub-module, barrel_shift_stage: a combinational single log stage (parameters WIDTH, SHIFT = 2^i).
  - Inputs: data, enable bit, op.
  - Outputs: data, carry-candidate update.
  - Instantiated AMT_W times by a generate loop. Registers are placed after every STAGES_PER_REG instances and after the last one.

Test Plan:
- Setup: WIDTH=32, STAGES_PER_REG=2, out_ready=1.
- Basic modes:
  - a=0x00000099, op=SLL, amt=1 -> y=0x00000132, carry=0, zero=0, exactly 3 cycles after acceptance.
  - a=0x00000099, SRL, amt=4 -> y=0x00000009, carry=1.
  - a=0x80000099, SRA, amt=4 -> y=0xF8000009, carry=1.
- Rotates:
  - a=0x00000099, ROR, amt=4 -> y=0x90000009, carry=1.
  - a=0x80000001, ROL, amt=1 -> y=0x00000003, carry=1.
- Boundaries:
  - a=0x00000099, SLL, amt=31 -> y=0x80000000, carry=0.
  - a=0x00000002, SRL, amt=2 -> y=0, zero=1, carry=1.
  - amt=0, any op -> y=a, carry=0.
  - op=111 -> pass-through.
- Backpressure:
  - Send 6 back-to-back beats, then drop out_ready for 3 cycles mid-stream.
  - in_ready=0 and out_* held while stalled.
  - All 6 results arrive in order, none lost or duplicated.
  - 1 beat/cycle once out_ready returns to 1.
- Reset mid-flight:
  - Assert rst_n=0 asynchronously (between clk edges) with 3 beats in flight.
  - out_valid drops to 0 immediately.
  - After release, no stale beat appears; a new beat emerges with latency 3.
